// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice walks WIDTH bits LSB first behind a valid/ready handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the operation into a - b.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
    logic             r_carry, r_cout, r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_accept, w_last, w_s, w_c, w_sub;
    logic [WIDTH-1:0] w_acc_nxt, w_b_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Subtraction is a + ~b + 1, so only the load values change.
    assign w_b_load  = w_sub ? ~b : b;
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_last    = (r_state == ADD) && (r_cnt == CW'(WIDTH - 1));
    assign w_s       = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c       = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_acc   <= '0;
            r_carry <= w_sub ? 1'b1 : cin;
            r_cnt   <= '0;
        end else if (r_state == ADD) begin
            r_acc   <= w_acc_nxt;
            r_carry <= w_c;
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_cnt   <= r_cnt + CW'(1);
            // r_carry here is still the carry into the MSB.
            if (w_last) begin
                r_sum  <= w_acc_nxt;
                r_cout <= w_c;
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end

    // Partial sums are only exposed while adding; otherwise the last result holds.
    assign sum  = busy ? r_acc : r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, corner sequences, random vs model.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
    logic [W-1:0] a, b, sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin;
        logic [W-1:0] s;
        logic         co, ov;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                  input logic s_mode, output logic [W-1:0] s,
                                  output logic co, output logic ov);
        int ux, uy, sx, sy, full, sfull;
        ux = int'(x);
        uy = int'(y);
        sx = x[W-1] ? ux - (1 << W) : ux;
        sy = y[W-1] ? uy - (1 << W) : uy;
        if (s_mode) begin
            full  = ux - uy;
            co    = (ux >= uy);
            sfull = sx - sy;
        end else begin
            full  = ux + uy + int'(c);
            co    = (full >= (1 << W));
            sfull = sx + sy + int'(c);
        end
        s  = W'(full);
        ov = (sfull > (1 << (W - 1)) - 1) || (sfull < -(1 << (W - 1)));
    endfunction

    // Entered and left at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic s_mode, input logic ordy, input logic noise,
                          input string tag, output logic [W-1:0] rs,
                          output logic rc, output logic ro);
        int n;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        a = x; b = y; cin = c;
`ifdef SERIAL_ADDER_SUB_EN
        sub = s_mode;
`endif
        in_valid  = 1'b1;
        out_ready = ordy;
        @(negedge clk);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        if (noise) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub = 1'($urandom);
`endif
        end else begin
            in_valid = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'(W));
        rs = sum; rc = cout; ro = ovf;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " in_ready after"}, 32'(in_ready), 32'd1);
        chk({tag, " out_valid after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] rs, es;
        logic         rc, ro, ec, eo;
        int           acc_e[$];
        logic [W-1:0] exp_q[$];
        int           issued, done, n;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i), rs, rc, ro);
            chk($sformatf("vec%0d sum", i), 32'(rs), 32'(tbl[i].s));
            chk($sformatf("vec%0d cout", i), 32'(rc), 32'(tbl[i].co));
            chk($sformatf("vec%0d ovf", i), 32'(ro), 32'(tbl[i].ov));
        end

        // DONE held by out_ready low; new in_valid must be ignored.
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("hold latency", 32'(n), 32'(W));
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            chk("hold sum", 32'(sum), 32'h46);
            chk("hold cout", 32'(cout), 32'd0);
            chk("hold ovf", 32'(ovf), 32'd0);
            chk("hold out_valid", 32'(out_valid), 32'd1);
            chk("hold in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release in_ready", 32'(in_ready), 32'd1);
        chk("release out_valid", 32'(out_valid), 32'd0);
        chk("retain sum", 32'(sum), 32'h46);
        @(negedge clk);
        chk("retain idle busy", 32'(busy), 32'd0);
        chk("retain idle sum", 32'(sum), 32'h46);

        // Reset at ADD edge 4, then reset wins over in_valid.
        a = 8'h55; b = 8'h11; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst sum", 32'(sum), 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("rst prio busy", 32'(busy), 32'd0);
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst", rs, rc, ro);
        chk("post_rst sum", 32'(rs), 32'h07);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, "sub1", rs, rc, ro);
        chk("sub1 sum", 32'(rs), 32'hFE);
        chk("sub1 cout", 32'(rc), 32'd0);
        run_op(8'h07, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, "sub2", rs, rc, ro);
        chk("sub2 sum", 32'(rs), 32'h02);
        chk("sub2 cout", 32'(rc), 32'd1);
`endif

        // Back-to-back with in_valid and out_ready held high.
        issued = 0; done = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && done < 3; cyc++) begin
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    chk($sformatf("b2b%0d sum", done), 32'(sum), 32'(exp_q.pop_front()));
                end else begin
                    chk("b2b unexpected result", 32'd1, 32'(exp_q.size()));
                end
                done++;
            end
            if (in_ready && issued < 3) begin
                a = W'($urandom); b = W'($urandom); cin = 1'b0;
                in_valid = 1'b1;
                model(a, b, 1'b0, 1'b0, es, ec, eo);
                exp_q.push_back(es);
                acc_e.push_back(cyc);
                issued++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b results", 32'(done), 32'd3);
        if (acc_e.size() == 3) begin
            chk("b2b spacing0", 32'(acc_e[1] - acc_e[0]), 32'd10);
            chk("b2b spacing1", 32'(acc_e[2] - acc_e[1]), 32'd10);
        end
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        out_ready = 1'b0;

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] x, y;
            logic c, sm;
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sm = 1'($urandom);
`else
            sm = 1'b0;
`endif
            model(x, y, c, sm, es, ec, eo);
            run_op(x, y, c, sm, 1'($urandom), 1'($urandom), $sformatf("rnd%0d", i), rs, rc, ro);
            chk($sformatf("rnd%0d sum", i), 32'(rs), 32'(es));
            chk($sformatf("rnd%0d cout", i), 32'(rc), 32'(ec));
            chk($sformatf("rnd%0d ovf", i), 32'(ro), 32'(eo));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand set a/b/cin present.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry out of MSB.
REQ-013 ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).
REQ-014 busy  output  1  high in ADD state.

Function
REQ-015 Block SHALL time-share one 1-bit full-adder slice (a_bit + b_bit + carry register) across all WIDTH bit positions, LSB first.
REQ-016 FSM SHALL have states IDLE, ADD, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==ADD).
REQ-017 IDLE: on edge with in_valid && in_ready, SHALL capture a, b into shift registers, cin into carry register, clear bit counter, go to ADD; otherwise stay IDLE.
REQ-018 ADD: each edge SHALL add bit 0 of A and B shift registers with carry register, shift the sum bit into sum register from MSB side, update carry register, shift A/B right, increment counter.
REQ-019 ADD SHALL last exactly WIDTH edges; with accept edge numbered 0, bit i processed at edge i+1, state DONE after edge WIDTH.
REQ-020 On the final ADD edge, SHALL record carry-into-MSB XOR carry-out as ovf, carry-out as cout.
REQ-021 DONE: sum, cout, ovf SHALL hold stable; on edge with out_ready go to IDLE; out_ready low holds DONE indefinitely.
REQ-022 in_valid while not IDLE SHALL be ignored; operands not sampled.
REQ-023 out_ready outside DONE SHALL have no effect.
REQ-024 sum/cout/ovf SHALL retain last result after return to IDLE until next accept's result overwrites them at DONE entry; intermediate sum register content visible only while busy.
REQ-025 Result SHALL equal (a + b + cin) mod 2^WIDTH, cout = bit WIDTH of that sum, for all operands.
REQ-026 Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH ADD, DONE handshake).

Reset
REQ-027 rst high at an edge SHALL force IDLE from any state, including mid-ADD, discarding the in-flight operation.
REQ-028 Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, counter=0, carry register=0.
REQ-029 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-030 Macro SERIAL_ADDER_SUB_EN defined: extra input port sub (1 bit), captured at accept; when 1, B shift register loads ~b and carry register loads 1 (cin ignored), giving a - b; cout = 1 means no borrow.
REQ-031 Macro undefined: no sub port; add-only behaviour per REQ-025.

Verification (WIDTH=8)
REQ-032 a=0x0F, b=0x01, cin=0, out_ready=1 -> out_valid high after edge 8, sum=0x10, cout=0, ovf=0, in_ready high after edge 9.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-034 out_ready held low 5 cycles in DONE -> sum/cout/ovf stable, out_valid=1, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-035 rst asserted at edge 4 of ADD -> after that edge in_ready=1, busy=0, out_valid=0, sum=0; subsequent op a=0x03, b=0x04 -> sum=0x07.
REQ-036 SERIAL_ADDER_SUB_EN defined, sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; a=0x07, b=0x05 -> sum=0x02, cout=1.
REQ-037 Back-to-back: in_valid held high with out_ready=1 -> accepts spaced exactly 10 edges apart, each result correct.
